// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/SPI memory port arbiter.
//   owner_e : which requester owns the read currently returning from SRAM
//   state_e : arbiter state (informational; drives the stall counter)
//   owner_of: maps the registered state to the read-data owner tag
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_CPU,
      OWN_SPI
   } owner_e;

   typedef enum logic [1:0] {
      IDLE,
      CPU_RD,
      SPI_RD,
      BLOCKED
   } state_e;

   localparam int unsigned SPI_ADDR_W = 24;

   // A collision can still carry an SPI read, so BLOCKED needs the extra bit.
   function automatic owner_e owner_of(input state_e st, input logic blk_spi_rd);
      owner_e o;
      o = OWN_NONE;
      case (st)
         CPU_RD:  o = OWN_CPU;
         SPI_RD:  o = OWN_SPI;
         BLOCKED: o = blk_spi_rd ? OWN_SPI : OWN_NONE;
         default: o = OWN_NONE;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM (1-cycle read latency) between
// the 6502 core and the SPI SRAM slave. SPI cannot be stalled and always wins;
// the CPU is held off through cpu_rdy and replays its request.
// Optional build macro: MEM_ARB_WPROT_EN (blocks SPI writes below WPROT_TOP
// and adds the sticky spi_wprot_err output).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cpu_en/wr/addr/wdata       CPU request (held by CPU while cpu_rdy=0)
//   cpu_rdata, cpu_rdy         CPU read data (held), CPU access accepted
//   spi_en/wr/addr/wdata       SPI single-cycle access pulse
//   spi_rdata                  SPI read data (held)
//   mem_en/wr/addr/wdata       SRAM request (combinational grant)
//   mem_rdata                  SRAM read data, one cycle after a read
//   stall_cnt                  saturating count of CPU stall cycles
//   spi_wprot_err              sticky write-protect violation (optional)
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned STALL_CNT_W = 8
`ifdef MEM_ARB_WPROT_EN
   ,
   parameter logic [ADDR_W-1:0] WPROT_TOP = ADDR_W'(16'h0400)
`endif
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cpu_en,
   input  logic                   cpu_wr,
   input  logic [ADDR_W-1:0]      cpu_addr,
   input  logic [DATA_W-1:0]      cpu_wdata,
   output logic [DATA_W-1:0]      cpu_rdata,
   output logic                   cpu_rdy,
   input  logic                   spi_en,
   input  logic                   spi_wr,
   input  logic [SPI_ADDR_W-1:0]  spi_addr,
   input  logic [DATA_W-1:0]      spi_wdata,
   output logic [DATA_W-1:0]      spi_rdata,
   output logic                   mem_en,
   output logic                   mem_wr,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [DATA_W-1:0]      mem_wdata,
   input  logic [DATA_W-1:0]      mem_rdata,
   output logic [STALL_CNT_W-1:0] stall_cnt
`ifdef MEM_ARB_WPROT_EN
   ,
   output logic                   spi_wprot_err
`endif
);

   logic [ADDR_W-1:0] spi_addr_mem;
   logic              unused_spi_addr_hi;
   logic              spi_act;
   logic              collide;
   logic              blk_spi_rd_d;
   logic              blk_spi_rd_q;
   state_e            state_d;
   state_e            state_q;
   owner_e            owner;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] spi_rdata_q;

   // SPI addresses wrap onto the smaller memory.
   assign spi_addr_mem       = spi_addr[ADDR_W-1:0];
   assign unused_spi_addr_hi = ^spi_addr[SPI_ADDR_W-1:ADDR_W];

   // spi_act: SPI access that really reaches memory this cycle.
`ifdef MEM_ARB_WPROT_EN
   logic wprot_hit;
   assign wprot_hit = spi_en && spi_wr && (spi_addr_mem < WPROT_TOP);
   assign spi_act   = spi_en && !wprot_hit;
`else
   assign spi_act   = spi_en;
`endif

   // Stall path is purely combinational so the CPU sees it in the same cycle.
   assign collide      = rst_n && cpu_en && spi_act;
   assign cpu_rdy      = !collide;
   assign blk_spi_rd_d = collide && !spi_wr;

   // Grant: SPI first, then CPU; idle memory port parks on the CPU inputs.
   always_comb begin
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (spi_act) begin
         mem_en    = 1'b1;
         mem_wr    = spi_wr;
         mem_addr  = spi_addr_mem;
         mem_wdata = spi_wdata;
      end else if (cpu_en) begin
         mem_en    = 1'b1;
         mem_wr    = cpu_wr;
      end
      if (!rst_n) begin
         mem_en = 1'b0;
         mem_wr = 1'b0;
      end
   end

   // Next state, evaluated every cycle regardless of the current state.
   always_comb begin
      state_d = IDLE;
      if (spi_act && cpu_en) begin
         state_d = BLOCKED;
      end else if (spi_act && !spi_wr) begin
         state_d = SPI_RD;
      end else if (!spi_act && cpu_en && !cpu_wr) begin
         state_d = CPU_RD;
      end
   end

   // Owner of the read data arriving from SRAM this cycle.
   assign owner = owner_of(state_q, blk_spi_rd_q);

   // Read return: pass-through for the owner, hold for everyone else.
   always_comb begin
      cpu_rdata = cpu_rdata_q;
      spi_rdata = spi_rdata_q;
      if (owner == OWN_CPU) begin
         cpu_rdata = mem_rdata;
      end
      if (owner == OWN_SPI) begin
         spi_rdata = mem_rdata;
      end
   end

   // State, owner bit, read-data holds, stall counter and sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         blk_spi_rd_q  <= 1'b0;
         cpu_rdata_q   <= '0;
         spi_rdata_q   <= '0;
         stall_cnt     <= '0;
`ifdef MEM_ARB_WPROT_EN
         spi_wprot_err <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         blk_spi_rd_q <= blk_spi_rd_d;
         if (owner == OWN_CPU) begin
            cpu_rdata_q <= mem_rdata;
         end
         if (owner == OWN_SPI) begin
            spi_rdata_q <= mem_rdata;
         end
         if ((state_d == BLOCKED) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
         end
`ifdef MEM_ARB_WPROT_EN
         if (wprot_hit) begin
            spi_wprot_err <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: SRAM behavioural model, a directed
// vector table, and hand-written sequences for saturation and async reset.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        cpu_en;
   logic        cpu_wr;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_rdy;
   logic        spi_en;
   logic        spi_wr;
   logic [23:0] spi_addr;
   logic [7:0]  spi_wdata;
   logic [7:0]  spi_rdata;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic [7:0]  stall_cnt;
`ifdef MEM_ARB_WPROT_EN
   logic        spi_wprot_err;
`endif

   int n_cmp;
   int n_err;

   mem_port_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_en    (cpu_en),
      .cpu_wr    (cpu_wr),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_rdy   (cpu_rdy),
      .spi_en    (spi_en),
      .spi_wr    (spi_wr),
      .spi_addr  (spi_addr),
      .spi_wdata (spi_wdata),
      .spi_rdata (spi_rdata),
      .mem_en    (mem_en),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .stall_cnt (stall_cnt)
`ifdef MEM_ARB_WPROT_EN
      ,
      .spi_wprot_err (spi_wprot_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous SRAM model, initial contents mem[a] = a[7:0] + 8'h11.
   logic [7:0] sram [0:65535];
   initial begin
      for (int a = 0; a < 65536; a++) sram[a] = 8'(a) + 8'h11;
      mem_rdata = 8'h00;
   end
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wr) sram[mem_addr] <= mem_wdata;
         else        mem_rdata      <= sram[mem_addr];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input logic ce, input logic cw, input logic [15:0] ca,
                        input logic [7:0] cd, input logic se, input logic sw,
                        input logic [23:0] sa, input logic [7:0] sd);
      cpu_en = ce; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cd;
      spi_en = se; spi_wr = sw; spi_addr = sa; spi_wdata = sd;
   endtask

   typedef struct {
      logic        ce;
      logic        cw;
      logic [15:0] ca;
      logic [7:0]  cd;
      logic        se;
      logic        sw;
      logic [23:0] sa;
      logic [7:0]  sd;
      logic        e_men;
      logic        e_mwr;
      logic [15:0] e_maddr;
      logic        e_rdy;
      logic [7:0]  e_crd;
      logic [7:0]  e_srd;
      logic [7:0]  e_stall;
   } vec_t;

   vec_t vecs [12];

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 24'h000000, 8'h00);

      //            ce cw  ca       cd     se  sw  sa          sd     men mwr maddr    rdy crd    srd    stall
      vecs[0]  = '{1, 1, 16'h1234, 8'h5A, 0, 0, 24'h000000, 8'h00, 1, 1, 16'h1234, 1, 8'h00, 8'h00, 8'd0};
      vecs[1]  = '{1, 0, 16'h1234, 8'h00, 0, 0, 24'h000000, 8'h00, 1, 0, 16'h1234, 1, 8'h5A, 8'h00, 8'd0};
      vecs[2]  = '{1, 0, 16'h0010, 8'h00, 1, 1, 24'h000020, 8'hA5, 1, 1, 16'h0020, 0, 8'h5A, 8'h00, 8'd1};
      vecs[3]  = '{1, 0, 16'h0010, 8'h00, 0, 0, 24'h000000, 8'h00, 1, 0, 16'h0010, 1, 8'h21, 8'h00, 8'd1};
      vecs[4]  = '{0, 0, 16'h0010, 8'h00, 0, 0, 24'h000000, 8'h00, 0, 0, 16'h0010, 1, 8'h21, 8'h00, 8'd1};
      vecs[5]  = '{0, 0, 16'h0010, 8'h00, 1, 0, 24'h012345, 8'h00, 1, 0, 16'h2345, 1, 8'h21, 8'h56, 8'd1};
      vecs[6]  = '{1, 0, 16'h0020, 8'h00, 0, 0, 24'h000000, 8'h00, 1, 0, 16'h0020, 1, 8'hA5, 8'h56, 8'd1};
      vecs[7]  = '{1, 1, 16'h0030, 8'h77, 1, 0, 24'h000020, 8'h00, 1, 0, 16'h0020, 0, 8'hA5, 8'hA5, 8'd2};
      vecs[8]  = '{1, 1, 16'h0030, 8'h77, 0, 0, 24'h000000, 8'h00, 1, 1, 16'h0030, 1, 8'hA5, 8'hA5, 8'd2};
      vecs[9]  = '{1, 0, 16'h0030, 8'h00, 1, 0, 24'hFF0030, 8'h00, 1, 0, 16'h0030, 0, 8'hA5, 8'h77, 8'd3};
      vecs[10] = '{1, 0, 16'h0030, 8'h00, 0, 0, 24'h000000, 8'h00, 1, 0, 16'h0030, 1, 8'h77, 8'h77, 8'd3};
      vecs[11] = '{0, 1, 16'h00AB, 8'h00, 0, 0, 24'h000000, 8'h00, 0, 0, 16'h00AB, 1, 8'h77, 8'h77, 8'd3};

      // Reset state, with a colliding request present to prove the gating.
      #12;
      drive(1'b1, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b0, 24'h000040, 8'h00);
      #1;
      chk("rst_cpu_rdy", 0, 32'(cpu_rdy), 32'(1'b1));
      chk("rst_mem_en", 0, 32'(mem_en), 32'(1'b0));
      chk("rst_mem_wr", 0, 32'(mem_wr), 32'(1'b0));
      chk("rst_cpu_rdata", 0, 32'(cpu_rdata), 32'(8'h00));
      chk("rst_spi_rdata", 0, 32'(spi_rdata), 32'(8'h00));
      chk("rst_stall_cnt", 0, 32'(stall_cnt), 32'(8'h00));
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 24'h000000, 8'h00);
      rst_n = 1'b1;

      // Directed vector table: combinational grant checked before the edge,
      // read data and counter checked just after it.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         drive(vecs[i].ce, vecs[i].cw, vecs[i].ca, vecs[i].cd,
               vecs[i].se, vecs[i].sw, vecs[i].sa, vecs[i].sd);
         #1;
         chk("mem_en", i, 32'(mem_en), 32'(vecs[i].e_men));
         chk("mem_wr", i, 32'(mem_wr), 32'(vecs[i].e_mwr));
         chk("mem_addr", i, 32'(mem_addr), 32'(vecs[i].e_maddr));
         chk("cpu_rdy", i, 32'(cpu_rdy), 32'(vecs[i].e_rdy));
         @(posedge clk);
         #1;
         chk("cpu_rdata", i, 32'(cpu_rdata), 32'(vecs[i].e_crd));
         chk("spi_rdata", i, 32'(spi_rdata), 32'(vecs[i].e_srd));
         chk("stall_cnt", i, 32'(stall_cnt), 32'(vecs[i].e_stall));
      end

      // SPI write data must have landed in memory.
      chk("sram_0020", 0, 32'(sram[16'h0020]), 32'(8'hA5));

      // Saturation: 300 colliding cycles on top of the 3 already counted.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, 16'h0030, 8'h00, 1'b1, 1'b0, 24'h000030, 8'h00);
         #1;
         if (i == 0) chk("sat_rdy", i, 32'(cpu_rdy), 32'(1'b0));
         @(posedge clk);
         #1;
         if (i == 250) chk("sat_254", i, 32'(stall_cnt), 32'(8'hFE));
         if (i == 251) chk("sat_255", i, 32'(stall_cnt), 32'(8'hFF));
      end
      chk("sat_hold", 0, 32'(stall_cnt), 32'(8'hFF));
      @(negedge clk);
      drive(1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b0, 24'h000000, 8'h00);
      @(posedge clk);
      #1;
      chk("sat_after", 0, 32'(stall_cnt), 32'(8'hFF));
      chk("rd_0010", 0, 32'(cpu_rdata), 32'(8'h21));

      // Asynchronous reset in the middle of a CPU read.
      @(negedge clk);
      drive(1'b1, 1'b0, 16'h0030, 8'h00, 1'b0, 1'b0, 24'h000000, 8'h00);
      @(posedge clk);
      #1;
      chk("mid_rd_data", 0, 32'(cpu_rdata), 32'(8'h77));
      spi_en = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_cpu_rdata", 0, 32'(cpu_rdata), 32'(8'h00));
      chk("arst_spi_rdata", 0, 32'(spi_rdata), 32'(8'h00));
      chk("arst_mem_en", 0, 32'(mem_en), 32'(1'b0));
      chk("arst_cpu_rdy", 0, 32'(cpu_rdy), 32'(1'b1));
      chk("arst_stall", 0, 32'(stall_cnt), 32'(8'h00));
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 24'h000000, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_cpu", 0, 32'(cpu_rdata), 32'(8'h00));
      chk("post_rst_spi", 0, 32'(spi_rdata), 32'(8'h00));
      @(negedge clk);
      drive(1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 1'b0, 24'h000000, 8'h00);
      @(posedge clk);
      #1;
      chk("post_rst_rd", 0, 32'(cpu_rdata), 32'(8'h5A));

`ifdef MEM_ARB_WPROT_EN
      // Protected SPI write colliding with a CPU read: write dropped, CPU granted.
      @(negedge clk);
      drive(1'b1, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b1, 24'h000100, 8'h99);
      #1;
      chk("wp_mem_wr", 0, 32'(mem_wr), 32'(1'b0));
      chk("wp_mem_addr", 0, 32'(mem_addr), 32'(16'h0010));
      chk("wp_cpu_rdy", 0, 32'(cpu_rdy), 32'(1'b1));
      @(posedge clk);
      #1;
      chk("wp_cpu_rdata", 0, 32'(cpu_rdata), 32'(8'h21));
      chk("wp_err", 0, 32'(spi_wprot_err), 32'(1'b1));
      @(negedge clk);
      drive(1'b1, 1'b0, 16'h0100, 8'h00, 1'b0, 1'b0, 24'h000000, 8'h00);
      @(posedge clk);
      #1;
      chk("wp_err_sticky", 0, 32'(spi_wprot_err), 32'(1'b1));
      chk("wp_not_written", 0, 32'(cpu_rdata), 32'(8'h11));
`endif

      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 24'h000000, 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous SRAM (1-cycle read latency) between the 6502 core and the SPI SRAM slave.
- The SPI slave cannot be stalled, so it always wins a collision. The CPU is held off through cpu_rdy and its access is replayed.
- Tracks which requester owns each in-flight read and returns read data to that requester.
- Keeps a per-port read-data hold so each port sees stable data until its next read.

Parameters:
- ADDR_W, 16, memory address width; SPI 24-bit addresses are truncated to ADDR_W (wrap-around).
- DATA_W, 8, data width of all ports.
- STALL_CNT_W, 8, width of the saturating CPU-stall debug counter.
- WPROT_TOP, 16'h0400, SPI writes below this address are blocked (only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_en  in  1  CPU access request valid this cycle
- cpu_wr  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data, valid the cycle after a granted read, then held
- cpu_rdy  out  1  0 = CPU access not taken this cycle; CPU must hold its request
- spi_en  in  1  SPI single-cycle access pulse
- spi_wr  in  1  SPI write
- spi_addr  in  24  SPI address
- spi_wdata  in  DATA_W  SPI write data
- spi_rdata  out  DATA_W  SPI read data, valid the cycle after spi_en read, then held
- mem_en  out  1  SRAM enable
- mem_wr  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, 1 cycle after mem_en read
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with cpu_en=1 and cpu_rdy=0

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. Reset clears the state register, the owner tag, both rdata holds and stall_cnt to 0.
- Outputs in reset: cpu_rdy=1, mem_en=0 and mem_wr=0.
- Grant (combinational, same cycle):
  - spi_en=1: SPI drives mem_*; mem_en=1, mem_wr=spi_wr, mem_addr=spi_addr[ADDR_W-1:0].
  - else cpu_en=1: CPU drives mem_*.
  - else mem_en=0; mem_addr and mem_wdata follow the CPU inputs, mem_wr=0.
- cpu_rdy = !(cpu_en && spi_en). This is combinational; there is no register in the rdy path.
- Owner tag register, enum OWN_NONE/OWN_CPU/OWN_SPI:
  - Set to the owner of a granted read.
  - Set to OWN_NONE after writes and idle cycles.
- Read data return:
  - Tag=OWN_CPU: cpu_rdata=mem_rdata (pass-through) and cpu_rdata_q<=mem_rdata. Otherwise cpu_rdata=cpu_rdata_q.
  - Tag=OWN_SPI: the same rule applies to spi_rdata and spi_rdata_q.
  - Each port's data never changes because of the other port's reads.
- State machine, states IDLE, CPU_RD, SPI_RD, BLOCKED. The state is registered; the next state is evaluated every cycle.
  - Any state, spi_en with cpu_en → BLOCKED. The CPU is replayed the next cycle, with its request held by the CPU.
  - Any state, spi_en read without cpu_en → SPI_RD.
  - Any state, cpu_en read without spi_en → CPU_RD.
  - Otherwise → IDLE.
  - The state is informational and drives stall_cnt. The tag is derived from it (CPU_RD→OWN_CPU, SPI_RD→OWN_SPI).
- Back-to-back SPI pulses on consecutive cycles stall the CPU for each of those cycles. The SPI slave's minimum pulse spacing is 8 clk, so there is no starvation.
- stall_cnt increments while cpu_en && !cpu_rdy and saturates at all-ones.
- Reset mid-read: the pending tag is discarded and the holds return to 0.

Optional Feature:
- MEM_ARB_WPROT_EN defined:
  - An SPI write with spi_addr[ADDR_W-1:0] < WPROT_TOP is suppressed: mem_en=0 and no CPU stall that cycle, so cpu_rdy stays 1 and the CPU is granted.
  - The extra output spi_wprot_err (1 bit) is set sticky. It is cleared only by reset.
  - SPI reads are unaffected.
- Undefined: every SPI write reaches memory, and the spi_wprot_err port does not exist.

Decomposition:
- Package mem_arb_pkg holds:
  - the owner typedef (OWN_NONE, OWN_CPU, OWN_SPI);
  - the state typedef (IDLE, CPU_RD, SPI_RD, BLOCKED).
- Flat module; no sub-module. A saturating counter is too small to split out.

Test Plan:
- CPU write 8'h5A @16'h1234, then CPU read @16'h1234 → mem_en both cycles. cpu_rdata=8'h5A one cycle after the read. cpu_rdy stays 1.
- CPU read @16'h0010 and SPI write 8'hA5 @24'h000020 in the same cycle:
  - cycle 1: mem_addr=16'h0020, mem_wr=1, cpu_rdy=0, stall_cnt=1;
  - cycle 2: CPU read granted;
  - cycle 3: cpu_rdata = memory[16'h0010].
- SPI read @24'h01_2345 → mem_addr=16'h2345 (truncation). spi_rdata = memory value the next cycle. cpu_rdata is unchanged (still the previous CPU value).
- Preload 300 collision cycles → stall_cnt saturates at 8'hFF.
- Assert rst_n=0 asynchronously mid-CPU-read → cpu_rdata=0, mem_en=0 and cpu_rdy=1 immediately. No stale data after release.
- With MEM_ARB_WPROT_EN: SPI write @24'h000100 plus a colliding CPU read → mem_wr=0, cpu_rdy=1, CPU read granted, spi_wprot_err=1 and it stays set.
